dsi_lane_sequencer: RTL and testbench
=====================================

Name: dsi_lane_sequencer

Overview:
- Drives the State / RGB_in / Type-paired inputs of a P/N pair of DSI DAC slave instances (Type=1 P line, Type=0 N line).
- Sequences one D-PHY-style burst: LP-11 stop → LP-01 → LP-00 → HS prepare → HS zero → sync byte → payload bytes → HS trail → LP-11.
- Accepts payload bytes over a valid/ready stream and serialises each byte as four 2-bit HS symbols.

Parameters:
- T_LPX, 4, cycles spent in each of LP-01 and LP-00 (1..255)
- T_PREP, 2, cycles in HS prepare (1..255)
- T_ZERO, 6, cycles in HS zero (1..255)
- T_TRAIL, 4, cycles in HS trail (1..255)
- T_EXIT, 8, minimum LP-11 cycles before a new request is accepted (1..255)
- SYNC_BYTE, 8'hB8, HS leader byte

Ports:
- clk, in, 1, system clock; all logic on rising edge
- rst, in, 1, synchronous active-high reset
- req_i, in, 1, burst request (level); sampled only in IDLE
- data_i, in, 8, payload byte
- data_valid_i, in, 1, data_i valid
- data_last_i, in, 1, qualifies data_i as final byte of burst
- data_ready_o, out, 1, byte accepted when data_valid_i & data_ready_o
- state_o, out, 2, to slave State (shared by P and N)
- rgb_p_o, out, 2, to P slave RGB_in
- rgb_n_o, out, 2, to N slave RGB_in
- busy_o, out, 1, high in any state except IDLE
- underrun_o, out, 1, one-cycle pulse on payload underrun

Behaviour:
- Output encoding:
  - LP: state_o=2'b10, rgb 2'b11 = LP-1, 2'b01 = LP-0.
  - HS prepare: state_o=2'b11.
  - HS zero/trail: state_o=2'b01, rgb = 2'b00.
  - HS symbol: state_o=2'b00, rgb_p_o = rgb_n_o = symbol.
- state_o, rgb_p_o, rgb_n_o and busy_o are registered; they change on the edge that enters a state.
- Reset (sync, active-high):
  - FSM → IDLE; state_o=10, rgb_p_o=rgb_n_o=11; busy_o=0, data_ready_o=0, underrun_o=0.
  - Shift register and symbol counter cleared.
  - Exit counter loaded with T_EXIT.
  - Reset mid-burst aborts immediately; no trail is emitted.
- FSM states and durations (duration counter reloads on entry):
  - IDLE: LP-11. Exit counter decrements to 0. If counter==0 and req_i=1, go to LP01 next cycle.
  - LP01: rgb_p_o=01, rgb_n_o=11; T_LPX cycles → LP00.
  - LP00: both 01; T_LPX cycles → PREP.
  - PREP: state_o=11; T_PREP cycles → ZERO.
  - ZERO: state_o=01; T_ZERO cycles → SYNC.
  - SYNC: 4 cycles, symbols SYNC_BYTE[7:6], [5:4], [3:2], [1:0] → DATA, or TRAIL on underrun.
  - DATA: 4 cycles per byte, MSB pair first.
  - TRAIL: state_o=01; T_TRAIL cycles → IDLE, exit counter reloaded with T_EXIT.
- Symbol counter: 2 bits, 0..3, wraps; reset to 0 on SYNC entry.
- Handshake:
  - data_ready_o is combinational: 1 iff (SYNC or DATA) & sym_cnt==3 & last_flag==0.
  - On an accepted byte: load byte into the shift register and latch data_last_i into last_flag; DATA continues next cycle with the new byte.
  - Byte accepted with data_last_i=1: that byte is sent, then TRAIL follows directly after its symbol 3.
  - At a fetch point with data_valid_i=0: pulse underrun_o for one cycle (the cycle after the fetch point) and go to TRAIL. No partial byte is sent.
- last_flag clears on IDLE entry.
- req_i deasserted mid-burst has no effect.
- req_i held high re-triggers after T_EXIT.
- data_valid_i outside a fetch point is ignored; data must be held until accepted.

Test Plan:
- Reset then req_i=1 held, defaults:
  - IDLE holds LP-11 for 8 cycles.
  - Then LP01 ×4, LP00 ×4, state 11 ×2, state 01 ×6.
  - Then HS symbols 2,3,2,0 (0xB8).
- Burst of bytes 0x1B (last=0) and 0xE4 (last=1), valid presented from SYNC onward:
  - Symbols after sync: 0,1,2,3 then 3,2,1,0.
  - Then state 01 ×4, then LP-11.
  - data_ready_o pulses exactly twice.
- data_valid_i=0 at the sync fetch point:
  - underrun_o=1 for one cycle.
  - Trail follows the sync symbols with no data symbols.
  - busy_o falls 4 cycles later.
- rst asserted during DATA symbol 1:
  - Next cycle state_o=10, rgb 11/11, busy_o=0.
  - No new burst until 8 cycles of LP-11 have elapsed.
- Back-to-back bursts with req_i held:
  - Exactly T_EXIT=8 LP-11 cycles between the last trail cycle and the next LP01.
- Parameter override T_LPX=1, T_ZERO=1:
  - Each of LP01, LP00 and ZERO lasts exactly one cycle.
  - Sync begins on cycle 1+1+1+2+1 after the request is sampled.

Source files
------------

// File: rtl/dsi_lane_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dsi_lane_sequencer
// Brief    : Drives a P/N pair of DSI DAC slaves through one LP/HS burst,
//            serialising streamed payload bytes as 2-bit HS symbols.
// Revision : 1.0 - initial release
// ============================================================================
module dsi_lane_sequencer #(
  parameter int unsigned T_LPX     = 4,
  parameter int unsigned T_PREP    = 2,
  parameter int unsigned T_ZERO    = 6,
  parameter int unsigned T_TRAIL   = 4,
  parameter int unsigned T_EXIT    = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'hB8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_i,
  input  logic [7:0] data_i,
  input  logic       data_valid_i,
  input  logic       data_last_i,
  output logic       data_ready_o,
  output logic [1:0] state_o,
  output logic [1:0] rgb_p_o,
  output logic [1:0] rgb_n_o,
  output logic       busy_o,
  output logic       underrun_o
);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_lp01  = 3'd1;
  localparam logic [2:0] c_st_lp00  = 3'd2;
  localparam logic [2:0] c_st_prep  = 3'd3;
  localparam logic [2:0] c_st_zero  = 3'd4;
  localparam logic [2:0] c_st_sync  = 3'd5;
  localparam logic [2:0] c_st_data  = 3'd6;
  localparam logic [2:0] c_st_trail = 3'd7;

  localparam logic [7:0] c_lpx_m1   = 8'(T_LPX - 1);
  localparam logic [7:0] c_prep_m1  = 8'(T_PREP - 1);
  localparam logic [7:0] c_zero_m1  = 8'(T_ZERO - 1);
  localparam logic [7:0] c_trail_m1 = 8'(T_TRAIL - 1);
  localparam logic [7:0] c_exit     = 8'(T_EXIT);

  logic [2:0] r_state, w_state_nxt;
  logic [7:0] r_dur, w_dur_nxt;
  logic [7:0] r_exit, w_exit_nxt;
  logic [1:0] r_sym, w_sym_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic       r_last, w_last_nxt;

  logic [1:0] r_state_out, w_state_out;
  logic [1:0] r_rgb_p, w_rgb_p;
  logic [1:0] r_rgb_n, w_rgb_n;
  logic       r_busy, w_busy;
  logic       r_underrun;

  logic w_hs_sym, w_fetch, w_underrun, w_exit_done;

  assign w_hs_sym     = (r_state == c_st_sync) || (r_state == c_st_data);
  assign w_fetch      = w_hs_sym && (r_sym == 2'd3);
  assign data_ready_o = w_fetch && !r_last;
  assign w_underrun   = data_ready_o && !data_valid_i;
  // The counter reaches zero on this edge, so IDLE dwells exactly T_EXIT cycles.
  assign w_exit_done  = (r_exit <= 8'd1);

  assign state_o    = r_state_out;
  assign rgb_p_o    = r_rgb_p;
  assign rgb_n_o    = r_rgb_n;
  assign busy_o     = r_busy;
  assign underrun_o = r_underrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dur   <= 8'd0;
      r_exit  <= c_exit;
      r_sym   <= 2'd0;
      r_shift <= 8'd0;
      r_last  <= 1'b0;
    end else begin
      r_dur   <= w_dur_nxt;
      r_exit  <= w_exit_nxt;
      r_sym   <= w_sym_nxt;
      r_shift <= w_shift_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dur_nxt   = (r_dur != 8'd0) ? (r_dur - 8'd1) : 8'd0;
    w_exit_nxt  = r_exit;
    w_sym_nxt   = r_sym;
    w_shift_nxt = r_shift;
    w_last_nxt  = r_last;
    case (r_state)
      c_st_idle: begin
        if (r_exit != 8'd0) w_exit_nxt = r_exit - 8'd1;
        if (w_exit_done && req_i) begin
          w_state_nxt = c_st_lp01;
          w_dur_nxt   = c_lpx_m1;
        end
      end
      c_st_lp01: if (r_dur == 8'd0) begin
        w_state_nxt = c_st_lp00;
        w_dur_nxt   = c_lpx_m1;
      end
      c_st_lp00: if (r_dur == 8'd0) begin
        w_state_nxt = c_st_prep;
        w_dur_nxt   = c_prep_m1;
      end
      c_st_prep: if (r_dur == 8'd0) begin
        w_state_nxt = c_st_zero;
        w_dur_nxt   = c_zero_m1;
      end
      c_st_zero: if (r_dur == 8'd0) begin
        w_state_nxt = c_st_sync;
        w_sym_nxt   = 2'd0;
        w_shift_nxt = SYNC_BYTE;
      end
      c_st_sync, c_st_data: begin
        if (r_sym != 2'd3) begin
          w_sym_nxt   = r_sym + 2'd1;
          w_shift_nxt = {r_shift[5:0], 2'b00};
        end else if (r_last || !data_valid_i) begin
          w_state_nxt = c_st_trail;
          w_dur_nxt   = c_trail_m1;
        end else begin
          w_state_nxt = c_st_data;
          w_sym_nxt   = 2'd0;
          w_shift_nxt = data_i;
          w_last_nxt  = data_last_i;
        end
      end
      c_st_trail: if (r_dur == 8'd0) begin
        w_state_nxt = c_st_idle;
        w_exit_nxt  = c_exit;
        w_last_nxt  = 1'b0;
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  // Outputs are decoded from the next state so they change on the entering edge.
  always_comb begin
    w_state_out = 2'b10;
    w_rgb_p     = 2'b11;
    w_rgb_n     = 2'b11;
    w_busy      = 1'b1;
    case (w_state_nxt)
      c_st_idle: w_busy = 1'b0;
      c_st_lp01: w_rgb_p = 2'b01;
      c_st_lp00: begin
        w_rgb_p = 2'b01;
        w_rgb_n = 2'b01;
      end
      c_st_prep: begin
        w_state_out = 2'b11;
        w_rgb_p     = 2'b00;
        w_rgb_n     = 2'b00;
      end
      c_st_zero, c_st_trail: begin
        w_state_out = 2'b01;
        w_rgb_p     = 2'b00;
        w_rgb_n     = 2'b00;
      end
      c_st_sync, c_st_data: begin
        w_state_out = 2'b00;
        w_rgb_p     = w_shift_nxt[7:6];
        w_rgb_n     = w_shift_nxt[7:6];
      end
      default: w_busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_out <= 2'b10;
      r_rgb_p     <= 2'b11;
      r_rgb_n     <= 2'b11;
      r_busy      <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_state_out <= w_state_out;
      r_rgb_p     <= w_rgb_p;
      r_rgb_n     <= w_rgb_n;
      r_busy      <= w_busy;
      r_underrun  <= w_underrun;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dsi_lane_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsi_lane_sequencer
// Brief    : Directed bench for dsi_lane_sequencer (default and short timing).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsi_lane_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req, valid, last, req1, valid1;
  logic [7:0] data;
  logic       ready0, busy0, ur0, ready1, busy1, ur1;
  logic [1:0] st0, p0, n0, st1, p1, n1;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         ready_cnt = 0;

  always #5 clk = ~clk;

  dsi_lane_sequencer dut0 (
    .clk(clk), .rst(rst), .req_i(req), .data_i(data), .data_valid_i(valid),
    .data_last_i(last), .data_ready_o(ready0), .state_o(st0), .rgb_p_o(p0),
    .rgb_n_o(n0), .busy_o(busy0), .underrun_o(ur0)
  );

  dsi_lane_sequencer #(.T_LPX(1), .T_ZERO(1)) dut1 (
    .clk(clk), .rst(rst), .req_i(req1), .data_i(8'h00), .data_valid_i(valid1),
    .data_last_i(1'b0), .data_ready_o(ready1), .state_o(st1), .rgb_p_o(p1),
    .rgb_n_o(n1), .busy_o(busy1), .underrun_o(ur1)
  );

  always @(negedge clk) if (ready0 === 1'b1) ready_cnt++;

  function automatic logic [7:0] pack(input logic [1:0] s, input logic [1:0] p,
                                      input logic [1:0] n, input logic b);
    return {1'b0, s, p, n, b};
  endfunction

  function automatic logic [7:0] obs(input bit inst);
    return inst ? {1'b0, st1, p1, n1, busy1} : {1'b0, st0, p0, n0, busy0};
  endfunction

  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic cycn(input bit inst, input string tag, input int cnt,
                      input logic [1:0] s, input logic [1:0] p,
                      input logic [1:0] n, input logic b);
    for (int i = 0; i < cnt; i++) begin
      @(negedge clk);
      chk(tag, obs(inst), pack(s, p, n, b));
    end
  endtask

  task automatic sym(input bit inst, input string tag, input logic [1:0] v);
    cycn(inst, tag, 1, 2'b00, v, v, 1'b1);
  endtask

  // LP01 through ZERO with default timing on dut0
  task automatic preamble0();
    cycn(0, "lp01", 4, 2'b10, 2'b01, 2'b11, 1'b1);
    cycn(0, "lp00", 4, 2'b10, 2'b01, 2'b01, 1'b1);
    cycn(0, "prep", 2, 2'b11, 2'b00, 2'b00, 1'b1);
    cycn(0, "zero", 6, 2'b01, 2'b00, 2'b00, 1'b1);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; data = 8'h00; valid = 1'b0; last = 1'b0;
    req1 = 1'b0; valid1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_out", obs(0), pack(2'b10, 2'b11, 2'b11, 1'b0));
    chk("reset_ready_ur", {6'd0, ready0, ur0}, 8'h00);
    rst = 1'b0; req = 1'b1;

    // First burst: exit dwell, preamble, sync, two bytes
    cycn(0, "idle_after_reset", 7, 2'b10, 2'b11, 2'b11, 1'b0);
    preamble0();
    sym(0, "sync0", 2'd2);
    data = 8'h1B; valid = 1'b1; last = 1'b0; ready_cnt = 0;
    sym(0, "sync1", 2'd3);
    sym(0, "sync2", 2'd2);
    sym(0, "sync3", 2'd0);
    chk("ready_sync_fetch", {7'd0, ready0}, 8'h01);
    sym(0, "b0_s0", 2'd0);
    data = 8'hE4; last = 1'b1;
    sym(0, "b0_s1", 2'd1);
    sym(0, "b0_s2", 2'd2);
    sym(0, "b0_s3", 2'd3);
    chk("ready_b0_fetch", {7'd0, ready0}, 8'h01);
    sym(0, "b1_s0", 2'd3);
    valid = 1'b0; last = 1'b0;
    sym(0, "b1_s1", 2'd2);
    sym(0, "b1_s2", 2'd1);
    sym(0, "b1_s3", 2'd0);
    chk("ready_after_last", {7'd0, ready0}, 8'h00);
    cycn(0, "trail", 1, 2'b01, 2'b00, 2'b00, 1'b1);
    chk("no_underrun", {7'd0, ur0}, 8'h00);
    cycn(0, "trail", 3, 2'b01, 2'b00, 2'b00, 1'b1);
    chk("ready_pulses", 8'(ready_cnt), 8'd2);

    // Back-to-back burst; req dropped mid-burst; underrun at sync fetch
    cycn(0, "b2b_idle", 8, 2'b10, 2'b11, 2'b11, 1'b0);
    cycn(0, "b2b_lp01", 4, 2'b10, 2'b01, 2'b11, 1'b1);
    req = 1'b0;
    cycn(0, "lp00", 4, 2'b10, 2'b01, 2'b01, 1'b1);
    cycn(0, "prep", 2, 2'b11, 2'b00, 2'b00, 1'b1);
    cycn(0, "zero", 6, 2'b01, 2'b00, 2'b00, 1'b1);
    sym(0, "ur_sync0", 2'd2);
    sym(0, "ur_sync1", 2'd3);
    sym(0, "ur_sync2", 2'd2);
    sym(0, "ur_sync3", 2'd0);
    chk("ready_ur_fetch", {7'd0, ready0}, 8'h01);
    cycn(0, "ur_trail", 1, 2'b01, 2'b00, 2'b00, 1'b1);
    chk("underrun_pulse", {7'd0, ur0}, 8'h01);
    cycn(0, "ur_trail", 1, 2'b01, 2'b00, 2'b00, 1'b1);
    chk("underrun_single", {7'd0, ur0}, 8'h00);
    cycn(0, "ur_trail", 2, 2'b01, 2'b00, 2'b00, 1'b1);
    cycn(0, "ur_busy_fall", 1, 2'b10, 2'b11, 2'b11, 1'b0);

    // Third burst, reset during data symbol 1
    req = 1'b1;
    cycn(0, "idle3", 7, 2'b10, 2'b11, 2'b11, 1'b0);
    preamble0();
    data = 8'h1B; valid = 1'b1; last = 1'b0;
    sym(0, "r_sync0", 2'd2);
    sym(0, "r_sync1", 2'd3);
    sym(0, "r_sync2", 2'd2);
    sym(0, "r_sync3", 2'd0);
    sym(0, "r_b0_s0", 2'd0);
    sym(0, "r_b0_s1", 2'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midburst_reset", obs(0), pack(2'b10, 2'b11, 2'b11, 1'b0));
    chk("midburst_reset_ready", {7'd0, ready0}, 8'h00);
    rst = 1'b0; valid = 1'b0;
    cycn(0, "post_reset_idle", 7, 2'b10, 2'b11, 2'b11, 1'b0);
    cycn(0, "post_reset_lp01", 1, 2'b10, 2'b01, 2'b11, 1'b1);

    // Short-timing instance: request sampled in this cycle
    req = 1'b0; req1 = 1'b1;
    cycn(1, "s_lp01", 1, 2'b10, 2'b01, 2'b11, 1'b1);
    cycn(1, "s_lp00", 1, 2'b10, 2'b01, 2'b01, 1'b1);
    cycn(1, "s_prep", 2, 2'b11, 2'b00, 2'b00, 1'b1);
    cycn(1, "s_zero", 1, 2'b01, 2'b00, 2'b00, 1'b1);
    req1 = 1'b0;
    sym(1, "s_sync0", 2'd2);
    sym(1, "s_sync1", 2'd3);
    sym(1, "s_sync2", 2'd2);
    sym(1, "s_sync3", 2'd0);
    cycn(1, "s_trail", 1, 2'b01, 2'b00, 2'b00, 1'b1);
    chk("s_underrun", {7'd0, ur1}, 8'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
